// File: rtl/imem_boot_loader_pkg.sv
// imem_boot_loader_pkg: shared FSM state encoding and sizing constants for the boot loader
package imem_boot_loader_pkg;
  localparam int ADDR_W_DEF = 16;
  localparam int BYTES_PER_WORD = 4;
  typedef enum logic [2:0] {IDLE, LOAD, WRITE, DONE, RUN} state_t;
endpackage

// File: rtl/imem_boot_loader_if.sv
// imem_boot_loader_if: load control, byte stream, CPU fetch address and instruction-memory write port
// slave = loader side, master = driver/CPU/memory side
interface imem_boot_loader_if;
  logic        load_start;
  logic [15:0] word_count;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic [31:0] fetch_addr;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_we;
  logic        cpu_run;
  logic        load_done;
  modport slave (
    input  load_start, word_count, byte_valid, byte_data, fetch_addr,
    output byte_ready, mem_addr, mem_wdata, mem_we, cpu_run, load_done
  );
  modport master (
    output load_start, word_count, byte_valid, byte_data, fetch_addr,
    input  byte_ready, mem_addr, mem_wdata, mem_we, cpu_run, load_done
  );
endinterface

// File: rtl/imem_boot_loader_word_packer.sv
// word_packer: shifts four accepted bytes into a 32-bit word in the configured byte order
// clk/rst, clr restarts the byte count, en = byte accepted, data = byte, word = packed word, last = en on the 4th byte
module word_packer
  import imem_boot_loader_pkg::*;
#(
  parameter bit BIG_ENDIAN = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        en,
  input  logic [7:0]  data,
  output logic [31:0] word,
  output logic        last
);
  logic [1:0] cnt;
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt  <= '0;
      word <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt  <= cnt + 2'd1;
      word <= BIG_ENDIAN ? {word[23:0], data} : {data, word[31:8]};
    end
  end
  // the 2-bit count wraps to 0 on the byte that completes the word
  assign last = en && cnt == 2'(BYTES_PER_WORD - 1);
endmodule

// File: rtl/imem_boot_loader.sv
// imem_boot_loader: loads a byte-streamed program into instruction memory, then releases the CPU
// clk/rst plain; bus (slave) carries load control, byte stream, fetch address and memory write port
module imem_boot_loader
  import imem_boot_loader_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter bit BIG_ENDIAN = 1'b1
) (
  input logic                clk,
  input logic                rst,
  imem_boot_loader_if.slave  bus
);
  state_t            state, nxt;
  logic [ADDR_W-1:0] word_ptr;
  logic [15:0]       count, written;
  logic [31:0]       packed_word;
  logic              start, xfer, last;
  assign start = bus.load_start && (state == IDLE || state == RUN);
  assign xfer  = bus.byte_valid && bus.byte_ready;
  word_packer #(.BIG_ENDIAN(BIG_ENDIAN)) u_packer (
    .clk  (clk),
    .rst  (rst),
    .clr  (start),
    .en   (xfer),
    .data (bus.byte_data),
    .word (packed_word),
    .last (last)
  );
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= nxt;
  end
  // written counts words independently of word_ptr, which wraps with the memory size
  always_ff @(posedge clk) begin
    if (rst) begin
      word_ptr <= '0;
      count    <= '0;
      written  <= '0;
    end else if (start) begin
      word_ptr <= '0;
      count    <= bus.word_count;
      written  <= '0;
    end else if (state == WRITE) begin
      word_ptr <= word_ptr + ADDR_W'(1);
      written  <= written + 16'd1;
    end
  end
  always_comb begin
    nxt = state;
    unique case (state)
      IDLE, RUN: nxt = start ? (bus.word_count == 16'd0 ? DONE : LOAD) : state;
      LOAD:      nxt = last ? WRITE : LOAD;
      WRITE:     nxt = written + 16'd1 == count ? DONE : LOAD;
      DONE:      nxt = RUN;
      default:   nxt = IDLE;
    endcase
  end
  always_comb begin
    bus.byte_ready = state == LOAD;
    bus.mem_we     = state == WRITE;
    bus.cpu_run    = state == RUN;
    bus.load_done  = state == DONE;
    bus.mem_wdata  = packed_word;
    bus.mem_addr   = state == RUN ? bus.fetch_addr : 32'({word_ptr, 2'b00});
  end
endmodule

// File: tb/tb_imem_boot_loader.sv
// tb_imem_boot_loader: three loader variants (default, little-endian, 4-word memory) driven by one byte stream
module tb_imem_boot_loader;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  imem_boot_loader_if b0 ();
  imem_boot_loader_if b1 ();
  imem_boot_loader_if b2 ();
  assign b1.load_start = b0.load_start;
  assign b1.word_count = b0.word_count;
  assign b1.byte_valid = b0.byte_valid;
  assign b1.byte_data  = b0.byte_data;
  assign b1.fetch_addr = b0.fetch_addr;
  assign b2.load_start = b0.load_start;
  assign b2.word_count = b0.word_count;
  assign b2.byte_valid = b0.byte_valid;
  assign b2.byte_data  = b0.byte_data;
  assign b2.fetch_addr = b0.fetch_addr;
  imem_boot_loader dut0 (.clk(clk), .rst(rst), .bus(b0));
  imem_boot_loader #(.BIG_ENDIAN(1'b0)) dut1 (.clk(clk), .rst(rst), .bus(b1));
  imem_boot_loader #(.ADDR_W(2)) dut2 (.clk(clk), .rst(rst), .bus(b2));
  typedef struct {
    logic [31:0] a;
    logic [31:0] a2;
    logic [31:0] be;
    logic [31:0] le;
  } wr_t;
  wr_t        exp_q[$];
  logic [7:0] src_q[$];
  int         gap_lo = 0;
  int         gap_hi = 0;
  int         errors = 0;
  int         checks = 0;
  task automatic chk(string tag, logic [31:0] got, logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", tag, got, want);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #2;
  endtask
  // word i of a load: bytes go out MSB first; the model derives every variant's write from them
  task automatic push_word(logic [31:0] w, int i);
    wr_t e;
    src_q.push_back(w[31:24]);
    src_q.push_back(w[23:16]);
    src_q.push_back(w[15:8]);
    src_q.push_back(w[7:0]);
    e.a  = 32'(i * 4);
    e.a2 = 32'((i % 4) * 4);
    e.be = w;
    e.le = {w[7:0], w[15:8], w[23:16], w[31:24]};
    exp_q.push_back(e);
  endtask
  task automatic start(int n);
    tick();
    b0.load_start = 1'b1;
    b0.word_count = n[15:0];
    tick();
    b0.load_start = 1'b0;
    b0.word_count = 16'($urandom);
  endtask
  task automatic finish_load(string tag, output int cyc);
    cyc = 0;
    @(negedge clk);
    while (cyc < 4000 && !b0.load_done) begin
      @(negedge clk);
      cyc++;
    end
    chk({tag, "_done"}, 32'({b0.load_done, b1.load_done, b2.load_done}), 32'h7);
    @(negedge clk);
    chk({tag, "_pulse"}, 32'({b0.load_done, b1.load_done, b2.load_done}), 32'h0);
    chk({tag, "_run"}, 32'({b0.cpu_run, b1.cpu_run, b2.cpu_run}), 32'h7);
    chk({tag, "_pending"}, 32'(exp_q.size()), 32'h0);
  endtask
  task automatic chk_idle(string tag);
    chk({tag, "_ctl"}, 32'({b0.cpu_run, b0.mem_we, b0.byte_ready, b0.load_done,
                            b1.cpu_run, b1.mem_we, b1.byte_ready, b1.load_done,
                            b2.cpu_run, b2.mem_we, b2.byte_ready, b2.load_done}), 32'h0);
    chk({tag, "_addr0"}, b0.mem_addr, 32'h0);
    chk({tag, "_addr1"}, b1.mem_addr, 32'h0);
    chk({tag, "_addr2"}, b2.mem_addr, 32'h0);
    chk({tag, "_wdata"}, b0.mem_wdata | b1.mem_wdata | b2.mem_wdata, 32'h0);
  endtask
  task automatic chk_fetch(string tag);
    tick();
    b0.fetch_addr = $urandom;
    @(negedge clk);
    chk({tag, "_f0"}, b0.mem_addr, b0.fetch_addr);
    chk({tag, "_f1"}, b1.mem_addr, b0.fetch_addr);
    chk({tag, "_f2"}, b2.mem_addr, b0.fetch_addr);
  endtask
  // byte source: presents the queue head, holds it until accepted, inserts random idle gaps
  initial begin : source
    bit took;
    int gap;
    gap = 0;
    b0.byte_valid = 1'b0;
    b0.byte_data  = 8'h00;
    forever begin
      @(negedge clk);
      took = b0.byte_valid && b0.byte_ready;
      @(posedge clk);
      #1;
      if (took) begin
        void'(src_q.pop_front());
        gap = int'($urandom_range(gap_hi, gap_lo));
      end
      if (gap > 0) begin
        b0.byte_valid = 1'b0;
        gap--;
      end else begin
        b0.byte_valid = src_q.size() > 0;
        b0.byte_data  = src_q.size() > 0 ? src_q[0] : 8'($urandom);
      end
    end
  end
  // write monitor: every strobe must match the next expected word on all three variants
  always @(negedge clk) begin
    wr_t e;
    if (b0.mem_we || b1.mem_we || b2.mem_we) begin
      if (exp_q.size() == 0) begin
        chk("spurious_we", 32'({b0.mem_we, b1.mem_we, b2.mem_we}), 32'h0);
      end else begin
        e = exp_q.pop_front();
        chk("we_all", 32'({b0.mem_we, b1.mem_we, b2.mem_we}), 32'h7);
        chk("addr_be", b0.mem_addr, e.a);
        chk("data_be", b0.mem_wdata, e.be);
        chk("addr_le", b1.mem_addr, e.a);
        chk("data_le", b1.mem_wdata, e.le);
        chk("addr_aw2", b2.mem_addr, e.a2);
        chk("data_aw2", b2.mem_wdata, e.be);
      end
    end
  end
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, errors=%0d", errors);
    $fatal(1, "watchdog");
  end
  initial begin
    int cyc;
    int n;
    b0.load_start = 1'b0;
    b0.word_count = 16'd0;
    b0.fetch_addr = 32'hDEAD_BEEC;
    rst = 1'b1;
    repeat (3) tick();
    @(negedge clk);
    chk_idle("reset");
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk_idle("idle");
    push_word(32'h8C01_0004, 0);
    push_word(32'h0000_0000, 1);
    start(2);
    finish_load("two_words", cyc);
    chk_fetch("run_mux");
    b0.fetch_addr = 32'h0000_0010;
    @(negedge clk);
    chk("fetch_10", b0.mem_addr, 32'h0000_0010);
    push_word($urandom, 0);
    start(1);
    @(negedge clk);
    chk("restart_run_low", 32'({b0.cpu_run, b1.cpu_run, b2.cpu_run}), 32'h0);
    chk("restart_addr", b0.mem_addr, 32'h0);
    finish_load("restart", cyc);
    gap_lo = 3;
    gap_hi = 3;
    push_word(32'h1234_5678, 0);
    start(1);
    finish_load("stall", cyc);
    gap_lo = 0;
    gap_hi = 0;
    start(0);
    finish_load("zero", cyc);
    chk("zero_latency", 32'(cyc <= 1), 32'h1);
    src_q.push_back(8'hAB);
    src_q.push_back(8'hCD);
    start(1);
    for (int i = 0; i < 100 && src_q.size() != 0; i++) @(negedge clk);
    chk("partial_taken", 32'(src_q.size()), 32'h0);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk_idle("mid_reset");
    repeat (6) @(negedge clk);
    chk("mid_reset_ready", 32'({b0.byte_ready, b1.byte_ready, b2.byte_ready}), 32'h0);
    push_word($urandom, 0);
    start(1);
    finish_load("after_reset", cyc);
    gap_hi = 2;
    for (int k = 0; k < 8; k++) begin
      n = k == 0 ? 5 : int'($urandom_range(6, 1));
      for (int i = 0; i < n; i++) push_word($urandom, i);
      start(n);
      if (k % 2 == 1) begin
        tick();
        b0.load_start = 1'b1;
        b0.word_count = 16'd9;
        tick();
        b0.load_start = 1'b0;
      end
      finish_load($sformatf("rand%0d", k), cyc);
      chk_fetch($sformatf("rand%0d", k));
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
